alarm_timer_ctrl: RTL
=====================

Name: alarm_timer_ctrl

Overview:
- Avalon-MM master sequencer that owns the alarm system's 16-bit interval timer slave: configures it after reset, services its IRQ, and starts/stops it on user command.
- Converts timer timeouts into a 24-hour time-of-day (hh:mm:ss, binary) and raises a latched alarm on an hh:mm match.
- Sits between the timer slave and the alarm-clock front-end (display/buttons).

Parameters:
- TICKS_PER_SEC, 1, timer timeouts per second (period 50,000,000 clk at 1 s); range 1..255.
- CTRL_RUN, 4'h7, control word for start: START|CONT|ITO.
- CTRL_STOP, 4'h8, control word for stop.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tmr_address  out  3  timer slave address (0 status, 1 control)
- tmr_chipselect  out  1  timer chipselect
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- tmr_readdata  in  16  timer read data; registered, valid 1 cycle after address driven
- tmr_irq  in  1  timer interrupt, level
- cmd_start  in  1  pulse: resume timekeeping
- cmd_stop  in  1  pulse: pause timekeeping
- set_time  in  1  pulse: load set_hh/set_mm/set_ss
- set_hh  in  5  hours 0..23
- set_mm, set_ss  in  6 each  minutes/seconds 0..59
- alarm_en  in  1  alarm compare enable
- alarm_hh  in  5;  alarm_mm  in  6  alarm time
- alarm_ack  in  1  pulse: clear alarm_ring
- hh  out  5;  mm, ss  out  6 each  current time
- running  out  1  timer started by this block
- alarm_ring  out  1  latched alarm
- sec_pulse  out  1  one-cycle pulse per second increment

Behaviour:
- Reset values: hh=mm=ss=0, running=0, alarm_ring=0, sec_pulse=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, tick divider=0, FSM=INIT_STOP.
- All bus transfers are single-cycle (no waitrequest): chipselect asserted for exactly one cycle per access.
- FSM:
  - INIT_STOP: write CTRL_STOP to address 1 -> INIT_CLR.
  - INIT_CLR: write 0 to address 0 (clears stale timeout) -> START.
  - START: write CTRL_RUN to address 1; running<=1 -> IDLE.
  - IDLE, priority high to low:
    - cmd_stop and running -> STOP.
    - cmd_start and !running -> START.
    - tmr_irq and running -> RD_REQ.
  - STOP: write CTRL_STOP to address 1; running<=0 -> IDLE.
  - RD_REQ: chipselect=1, write_n=1, address=0 -> RD_WAIT.
  - RD_WAIT: sample tmr_readdata[0] (TO). TO=1 -> CLR; TO=0 (spurious) -> IDLE, no tick.
  - CLR: write 0 to address 0 -> TICK.
  - TICK: divider+1. On reaching TICKS_PER_SEC: divider<=0, advance time one second, sec_pulse=1 for this cycle. -> IDLE.
- cmd_start/cmd_stop are ignored outside IDLE, and when redundant (start while running, stop while stopped).
- Time advance: ss wraps 59->0 carrying to mm; mm wraps 59->0 carrying to hh; hh wraps 23->0. 23:59:59 -> 00:00:00.
- set_time:
  - Accepted in any state; loads hh/mm/ss and clears the divider next cycle.
  - Coincident with TICK: set_time wins; the tick is dropped and sec_pulse=0.
  - Out-of-range set values (hh>23, mm/ss>59) are ignored and the time is unchanged.
- Alarm:
  - alarm_ring<=1 on the TICK that produces ss==0 with hh==alarm_hh, mm==alarm_mm, alarm_en=1.
  - Not raised by set_time.
  - alarm_ack clears it; alarm_ack has priority over a coincident set.
  - alarm_en=0 does not clear an already-latched ring.
- Reset mid-transfer: all outputs return to reset values asynchronously and the INIT sequence reruns.
- IRQ latency: tmr_irq seen in IDLE -> clear write issued 3 cycles later -> time updated 4 cycles later.

Decomposition:
- Shared package alarm_pkg:
  - timer register address constants (ADDR_STATUS=0, ADDR_CONTROL=1).
  - control bit positions (ITO=0, CONT=1, START=2, STOP=3).
  - FSM state enum.
  - limits (HH_MAX=23, MS_MAX=59).
- Sub-module alarm_tod_counter: hh/mm/ss registers, wrap/carry, set_time load, alarm compare/latch. Driven by a single advance strobe from the FSM.

Test Plan:
- Reset release with timer model attached -> writes in order: (1,0x0008), (0,0x0000), (1,0x0007) on consecutive cycles; running=1.
- 3 timer IRQs, TICKS_PER_SEC=1 -> per IRQ: read addr 0, write addr 0, sec_pulse once; ss=3. With TICKS_PER_SEC=4: 3 IRQs -> ss=0, 4th IRQ -> ss=1.
- set 23:59:58, 2 ticks -> 23:59:59 then 00:00:00, one sec_pulse each.
- alarm 07:30 enabled, set 07:29:59, 1 tick -> alarm_ring=1 at 07:30:00; alarm_ack -> 0; further ticks at 07:30:xx do not re-raise.
- cmd_stop -> write (1,0x0008), running=0; IRQ while stopped ignored (no bus access); cmd_start -> write (1,0x0007).
- Spurious IRQ with status readdata=0 -> no clear write, time unchanged. set_time coincident with TICK -> loaded value kept, sec_pulse=0.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm timer controller.
// Holds the interval-timer register map, the control/status bit positions,
// the sequencer state encoding, the time-of-day limits and a range check
// used wherever a user-supplied time is accepted.
package alarm_pkg;

    // Interval timer register map
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;

    // Control register bit positions
    localparam int BIT_ITO   = 0;
    localparam int BIT_CONT  = 1;
    localparam int BIT_START = 2;
    localparam int BIT_STOP  = 3;

    // Status register: timeout flag
    localparam int BIT_TO = 0;

    // Time-of-day limits
    localparam logic [4:0] HH_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    typedef enum logic [3:0] {
        ST_INIT_STOP,
        ST_INIT_CLR,
        ST_START,
        ST_IDLE,
        ST_STOP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CLR,
        ST_TICK
    } state_t;

    function automatic logic time_valid(logic [4:0] h, logic [5:0] m, logic [5:0] s);
        return (h <= HH_MAX) && (m <= MS_MAX) && (s <= MS_MAX);
    endfunction

    function automatic logic [15:0] ctrl_word(logic [3:0] c);
        return {12'd0, c};
    endfunction

endpackage

// File: rtl/alarm_timer_ctrl_if.sv
// Avalon-MM link between the alarm controller and the 16-bit interval timer.
//   tmr_address    : register select (0 status, 1 control)
//   tmr_chipselect : one cycle per access
//   tmr_write_n    : low for a write, high for a read
//   tmr_writedata  : write data
//   tmr_readdata   : registered read data, valid the cycle after the address
//   tmr_irq        : level interrupt from the timer
interface alarm_timer_ctrl_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_readdata, tmr_irq
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_readdata, tmr_irq
    );
endinterface

// File: rtl/alarm_tod_counter.sv
// Binary 24-hour time-of-day counter with alarm latch.
//   clk, reset_n          : clock, async active-low reset
//   advance               : one-cycle strobe, add one second
//   set_time, set_hh/mm/ss: load a new time (ignored when out of range)
//   alarm_en, alarm_hh/mm : alarm compare
//   alarm_ack             : clears the latched alarm
//   hh, mm, ss            : current time
//   alarm_ring            : latched alarm
module alarm_tod_counter
    import alarm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    input  logic       set_time,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic [5:0] set_ss,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    input  logic       alarm_ack,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss,
    output logic       alarm_ring
);

    logic [4:0] hh_q, hh_d, inc_hh;
    logic [5:0] mm_q, mm_d, inc_mm;
    logic [5:0] ss_q, ss_d, inc_ss;
    logic       ring_q, ring_d;
    logic       set_ok;
    logic       raise;

    assign set_ok = set_time && time_valid(set_hh, set_mm, set_ss);

    always_comb begin
        inc_hh = hh_q;
        inc_mm = mm_q;
        inc_ss = ss_q + 6'd1;
        if (ss_q >= MS_MAX) begin
            inc_ss = 6'd0;
            inc_mm = mm_q + 6'd1;
            if (mm_q >= MS_MAX) begin
                inc_mm = 6'd0;
                inc_hh = (hh_q >= HH_MAX) ? 5'd0 : hh_q + 5'd1;
            end
        end
    end

    // Only a real second boundary onto hh:mm:00 rings; a load never does.
    assign raise = advance && !set_ok && alarm_en && (inc_ss == 6'd0) &&
                   (inc_hh == alarm_hh) && (inc_mm == alarm_mm);

    always_comb begin
        hh_d   = hh_q;
        mm_d   = mm_q;
        ss_d   = ss_q;
        ring_d = ring_q;
        if (set_ok) begin
            hh_d = set_hh;
            mm_d = set_mm;
            ss_d = set_ss;
        end else if (advance) begin
            hh_d = inc_hh;
            mm_d = inc_mm;
            ss_d = inc_ss;
        end
        if (alarm_ack) begin
            ring_d = 1'b0;
        end else if (raise) begin
            ring_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hh_q   <= 5'd0;
            mm_q   <= 6'd0;
            ss_q   <= 6'd0;
            ring_q <= 1'b0;
        end else begin
            hh_q   <= hh_d;
            mm_q   <= mm_d;
            ss_q   <= ss_d;
            ring_q <= ring_d;
        end
    end

    assign hh         = hh_q;
    assign mm         = mm_q;
    assign ss         = ss_q;
    assign alarm_ring = ring_q;

endmodule

// File: rtl/alarm_timer_ctrl.sv
// Alarm clock sequencer: owns the interval timer over Avalon-MM, turns its
// timeouts into seconds and feeds the time-of-day / alarm counter.
//   clk, reset_n            : clock, async active-low reset
//   tmr                     : timer bus (master side)
//   cmd_start, cmd_stop     : resume / pause timekeeping (pulses)
//   set_time, set_hh/mm/ss  : time load
//   alarm_en, alarm_hh/mm   : alarm setting
//   alarm_ack               : clear alarm_ring
//   hh, mm, ss              : current time
//   running                 : timer started by this block
//   alarm_ring, sec_pulse   : latched alarm, one pulse per second
//
// state      | meaning
// INIT_STOP  | after reset: stop the timer
// INIT_CLR   | clear a stale timeout flag
// START      | write run control word, running<=1
// IDLE       | wait for command or IRQ
// STOP       | write stop control word, running<=0
// RD_REQ     | read status register
// RD_WAIT    | status data valid, check TO
// CLR        | clear timeout flag
// TICK       | count divider, advance a second on wrap
module alarm_timer_ctrl
    import alarm_pkg::*;
#(
    parameter int         TICKS_PER_SEC = 1,
    parameter logic [3:0] CTRL_RUN  = (4'b1 << BIT_START) | (4'b1 << BIT_CONT) | (4'b1 << BIT_ITO),
    parameter logic [3:0] CTRL_STOP = (4'b1 << BIT_STOP)
) (
    input  logic               clk,
    input  logic               reset_n,
    alarm_timer_ctrl_if.master tmr,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic               set_time,
    input  logic [4:0]         set_hh,
    input  logic [5:0]         set_mm,
    input  logic [5:0]         set_ss,
    input  logic               alarm_en,
    input  logic [4:0]         alarm_hh,
    input  logic [5:0]         alarm_mm,
    input  logic               alarm_ack,
    output logic [4:0]         hh,
    output logic [5:0]         mm,
    output logic [5:0]         ss,
    output logic               running,
    output logic               alarm_ring,
    output logic               sec_pulse
);

    localparam logic [7:0] TPS = 8'(TICKS_PER_SEC);

    state_t      state_q, state_d;
    logic        armed_q;
    logic        running_q, running_d;
    logic [7:0]  div_q, div_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wd_q, wd_d;
    logic        set_ok;
    logic        div_hit;
    logic        advance;
    logic        unused_rd;

    assign set_ok  = set_time && time_valid(set_hh, set_mm, set_ss);
    assign div_hit = (div_q + 8'd1) == TPS;
    // A valid load in the same cycle as TICK swallows the second.
    assign advance = (state_q == ST_TICK) && div_hit && !set_ok;

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        case (state_q)
            // Hold one cycle after reset so the stop write is seen on the bus.
            ST_INIT_STOP: if (armed_q) state_d = ST_INIT_CLR;
            ST_INIT_CLR:  state_d = ST_START;
            ST_START: begin
                running_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmd_stop && running_q) begin
                    state_d = ST_STOP;
                end else if (cmd_start && !running_q) begin
                    state_d = ST_START;
                end else if (tmr.tmr_irq && running_q) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_STOP: begin
                running_d = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = tmr.tmr_readdata[BIT_TO] ? ST_CLR : ST_IDLE;
            ST_CLR:     state_d = ST_TICK;
            ST_TICK:    state_d = ST_IDLE;
            default:    state_d = ST_INIT_STOP;
        endcase
    end

    // Bus outputs are registered from the state being entered, so each
    // access is on the bus during its own state and read data is back by
    // the following state.
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = ADDR_STATUS;
        wd_d   = 16'd0;
        case (state_d)
            ST_INIT_STOP, ST_STOP: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = ADDR_CONTROL;
                wd_d   = ctrl_word(CTRL_STOP);
            end
            ST_INIT_CLR, ST_CLR: begin
                cs_d = 1'b1;
                wn_d = 1'b0;
            end
            ST_START: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = ADDR_CONTROL;
                wd_d   = ctrl_word(CTRL_RUN);
            end
            ST_RD_REQ: cs_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        div_d = div_q;
        if (set_ok) begin
            div_d = 8'd0;
        end else if (state_q == ST_TICK) begin
            div_d = div_hit ? 8'd0 : div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT_STOP;
            armed_q   <= 1'b0;
            running_q <= 1'b0;
            div_q     <= 8'd0;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            addr_q    <= 3'd0;
            wd_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            armed_q   <= 1'b1;
            running_q <= running_d;
            div_q     <= div_d;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
        end
    end

    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wn_q;
    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_writedata  = wd_q;
    assign unused_rd          = ^tmr.tmr_readdata[15:1];

    assign running   = running_q;
    assign sec_pulse = advance;

    alarm_tod_counter u_tod (
        .clk        (clk),
        .reset_n    (reset_n),
        .advance    (advance),
        .set_time   (set_time),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_ss     (set_ss),
        .alarm_en   (alarm_en),
        .alarm_hh   (alarm_hh),
        .alarm_mm   (alarm_mm),
        .alarm_ack  (alarm_ack),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .alarm_ring (alarm_ring)
    );

endmodule
